// File: rtl/bus_sram8_slave.sv
// Data-bus responder for an 8-bit asynchronous SRAM.
// Splits byte/half/word accesses into timed byte cycles.
module bus_sram8_slave #(
  parameter int ADDR_W   = 19,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              s_req,
  input  logic [31:0]       s_addr,
  input  logic              s_w_rb,
  input  logic [1:0]        s_acc,
  input  logic [31:0]       s_wdata,
  output logic              s_resp,
  output logic [31:0]       s_rdata,
  output logic              s_fault,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic                r_w, w_w;
  logic [1:0]          r_n, w_n;
  logic [1:0]          r_k, w_k;
  logic [31:0]         r_wdata, w_wdata;
  logic [31:0]         r_rbuf, w_rbuf;
  logic [3:0]          r_wcnt, w_wcnt;
  logic                r_ce_n, w_ce_n;
  logic                r_oe_n, w_oe_n;
  logic                r_we_n, w_we_n;
  logic [ADDR_W-1:0]   r_saddr, w_saddr;
  logic [7:0]          r_dq_o, w_dq_o;
  logic                r_dq_oe, w_dq_oe;
  logic                r_resp, w_resp;
  logic                r_fault, w_fault;
  logic [31:0]         r_rdata, w_rdata;
  logic                w_illegal;
  logic [1:0]          w_acc_n;
  logic [1:0]          w_k1;
  logic [31:0]         w_mask;
  logic                w_unused;

  assign w_unused = ^s_addr;
  assign w_k1     = r_k + 2'd1;

  always_comb begin
    w_illegal = 1'b0;
    w_acc_n   = 2'd0;
    unique case (1'b1)
      (s_acc == 2'd0): w_acc_n = 2'd0;
      (s_acc == 2'd1): begin
        w_acc_n   = 2'd1;
        w_illegal = s_addr[0];
      end
      (s_acc == 2'd2): begin
        w_acc_n   = 2'd3;
        w_illegal = |s_addr[1:0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // keep only the bytes this access actually fetched
  assign w_mask = (r_n == 2'd0) ? 32'h0000_00FF :
                  (r_n == 2'd1) ? 32'h0000_FFFF :
                                  32'hFFFF_FFFF;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_w     <= 1'b0;
      r_n     <= 2'd0;
      r_k     <= 2'd0;
      r_wdata <= '0;
      r_rbuf  <= '0;
      r_wcnt  <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_saddr <= '0;
      r_dq_o  <= '0;
      r_dq_oe <= 1'b0;
      r_resp  <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_w     <= w_w;
      r_n     <= w_n;
      r_k     <= w_k;
      r_wdata <= w_wdata;
      r_rbuf  <= w_rbuf;
      r_wcnt  <= w_wcnt;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_saddr <= w_saddr;
      r_dq_o  <= w_dq_o;
      r_dq_oe <= w_dq_oe;
      r_resp  <= w_resp;
      r_fault <= w_fault;
      r_rdata <= w_rdata;
    end
  end

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_w     = r_w;
    w_n     = r_n;
    w_k     = r_k;
    w_wdata = r_wdata;
    w_rbuf  = r_rbuf;
    w_wcnt  = r_wcnt;
    w_ce_n  = r_ce_n;
    w_oe_n  = r_oe_n;
    w_we_n  = r_we_n;
    w_saddr = r_saddr;
    w_dq_o  = r_dq_o;
    w_dq_oe = r_dq_oe;
    w_resp  = 1'b0;
    w_fault = 1'b0;
    w_rdata = r_rdata;
    unique case (r_state)
      S_IDLE: begin
        if (s_req) begin
          w_addr  = s_addr[ADDR_W-1:0];
          w_w     = s_w_rb;
          w_wdata = s_wdata;
          w_n     = w_acc_n;
          w_k     = 2'd0;
          w_wcnt  = '0;
          if (w_illegal) begin
            w_state = S_RESP;
            w_resp  = 1'b1;
            w_fault = 1'b1;
            w_rdata = '0;
          end else begin
            w_state = S_SETUP;
            w_ce_n  = 1'b0;
            w_saddr = s_addr[ADDR_W-1:0];
            w_dq_oe = s_w_rb;
            if (s_w_rb) w_dq_o = s_wdata[7:0];
          end
        end
      end
      S_SETUP: begin
        w_state = S_STROBE;
        w_wcnt  = '0;
        if (r_w) w_we_n = 1'b0;
        else     w_oe_n = 1'b0;
      end
      S_STROBE: begin
        if (r_wcnt == 4'(WAIT_CYC)) begin
          w_state = S_HOLD;
          w_we_n  = 1'b1;
          w_oe_n  = 1'b1;
          if (!r_w) w_rbuf[{r_k, 3'b000} +: 8] = sram_dq_i;
        end else begin
          w_wcnt = r_wcnt + 4'd1;
        end
      end
      S_HOLD: begin
        if (r_k < r_n) begin
          w_state = S_SETUP;
          w_k     = w_k1;
          w_saddr = r_addr + ADDR_W'(w_k1);
          if (r_w) w_dq_o = r_wdata[{w_k1, 3'b000} +: 8];
        end else begin
          w_state = S_RESP;
          w_ce_n  = 1'b1;
          w_dq_oe = 1'b0;
          w_resp  = 1'b1;
          if (!r_w) w_rdata = r_rbuf & w_mask;
        end
      end
      S_RESP:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  assign s_resp     = r_resp;
  assign s_fault    = r_fault;
  assign s_rdata    = r_rdata;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_addr  = r_saddr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;

endmodule

// File: tb/tb_bus_sram8_slave.sv
// Directed bench for bus_sram8_slave: two instances
// (WAIT_CYC=1 and WAIT_CYC=0) each backed by a byte SRAM model.
module tb_bus_sram8_slave;
  localparam int AW = 19;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          reqA = 0, wA = 0;
  logic [1:0]    accA = 0;
  logic [31:0]   addrA = 0, wdA = 0, rdA;
  logic          respA, fltA, ceA, oeA, weA, dqoeA;
  logic [AW-1:0] saA;
  logic [7:0]    dqoA, dqiA;

  logic          reqB = 0, wB = 0;
  logic [1:0]    accB = 0;
  logic [31:0]   addrB = 0, wdB = 0, rdB;
  logic          respB, fltB, ceB, oeB, weB, dqoeB;
  logic [AW-1:0] saB;
  logic [7:0]    dqoB, dqiB;

  logic [7:0] memA [0:(1<<AW)-1];
  logic [7:0] memB [0:(1<<AW)-1];

  bus_sram8_slave #(.ADDR_W(AW), .WAIT_CYC(1)) dutA (
    .clk(clk), .rstn(rstn), .s_req(reqA), .s_addr(addrA),
    .s_w_rb(wA), .s_acc(accA), .s_wdata(wdA), .s_resp(respA),
    .s_rdata(rdA), .s_fault(fltA), .sram_ce_n(ceA),
    .sram_oe_n(oeA), .sram_we_n(weA), .sram_addr(saA),
    .sram_dq_o(dqoA), .sram_dq_oe(dqoeA), .sram_dq_i(dqiA)
  );

  bus_sram8_slave #(.ADDR_W(AW), .WAIT_CYC(0)) dutB (
    .clk(clk), .rstn(rstn), .s_req(reqB), .s_addr(addrB),
    .s_w_rb(wB), .s_acc(accB), .s_wdata(wdB), .s_resp(respB),
    .s_rdata(rdB), .s_fault(fltB), .sram_ce_n(ceB),
    .sram_oe_n(oeB), .sram_we_n(weB), .sram_addr(saB),
    .sram_dq_o(dqoB), .sram_dq_oe(dqoeB), .sram_dq_i(dqiB)
  );

  always @(posedge clk) begin
    if (!ceA && !weA) memA[saA] <= dqoA;
    if (!ceB && !weB) memB[saB] <= dqoB;
  end
  assign dqiA = (!ceA && !oeA) ? memA[saA] : 8'h00;
  assign dqiB = (!ceB && !oeB) ? memB[saB] : 8'h00;

  int weLow = 0, oeLow = 0, oeWin = 0, ceWin = 0;
  int dqoeCyc = 0, bothLow = 0, ceLowB = 0;
  logic pOe = 1'b1, pCe = 1'b1;
  always @(negedge clk) begin
    if (!weA) weLow++;
    if (!oeA) oeLow++;
    if (!oeA && pOe) oeWin++;
    if (!ceA && pCe) ceWin++;
    if (dqoeA) dqoeCyc++;
    if ((!weA && !oeA) || (!weB && !oeB)) bothLow++;
    if (!ceB) ceLowB++;
    pOe = oeA;
    pCe = ceA;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit b, input logic r, input logic w,
                       input logic [1:0] acc, input logic [31:0] a,
                       input logic [31:0] d);
    if (b) begin
      reqB = r; wB = w; accB = acc; addrB = a; wdB = d;
    end else begin
      reqA = r; wA = w; accA = acc; addrA = a; wdA = d;
    end
  endtask

  task automatic access(input bit b, input logic w, input logic [1:0] acc,
                        input logic [31:0] a, input logic [31:0] d,
                        input int xreq, output int lat,
                        output logic [31:0] rd, output logic flt);
    int c;
    lat = -1;
    rd  = 'x;
    flt = 1'bx;
    @(negedge clk);
    drive(b, 1'b1, w, acc, a, d);
    @(posedge clk);
    c = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      reqA = 1'b0;
      reqB = 1'b0;
      if (b ? respB : respA) begin
        lat = c;
        rd  = b ? rdB : rdA;
        flt = b ? fltB : fltA;
        break;
      end
      if (c == xreq) drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h100, 32'h55);
      @(posedge clk);
      c++;
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        flt;
  int          s0, s1, s2, s3, s4, s5;
  logic        sawResp;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      memA[i] = 8'h00;
      memB[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ce_n", {31'd0, ceA}, 32'd1);
    chk("rst_oe_n", {31'd0, oeA}, 32'd1);
    chk("rst_we_n", {31'd0, weA}, 32'd1);
    chk("rst_dq_oe", {31'd0, dqoeA}, 32'd0);
    chk("rst_addr", 32'(saA), 32'd0);
    chk("rst_dq_o", {24'd0, dqoA}, 32'd0);
    chk("rst_resp", {30'd0, respA, fltA}, 32'd0);
    chk("rst_rdata", rdA, 32'd0);
    rstn = 1'b1;

    // word write 0x12345678 at 0x10
    s0 = weLow;
    access(0, 1, 2'd2, 32'h10, 32'h1234_5678, -1, lat, rd, flt);
    chk("ww_lat", lat, 17);
    chk("ww_fault", {31'd0, flt}, 32'd0);
    chk("ww_we_cycles", weLow - s0, 8);
    chk("ww_mem10", {24'd0, memA[19'h10]}, 32'h78);
    chk("ww_mem11", {24'd0, memA[19'h11]}, 32'h56);
    chk("ww_mem12", {24'd0, memA[19'h12]}, 32'h34);
    chk("ww_mem13", {24'd0, memA[19'h13]}, 32'h12);

    // word read back
    s0 = dqoeCyc; s1 = oeWin; s2 = oeLow;
    access(0, 0, 2'd2, 32'h10, 32'h0, -1, lat, rd, flt);
    chk("wr_lat", lat, 17);
    chk("wr_rdata", rd, 32'h1234_5678);
    chk("wr_fault", {31'd0, flt}, 32'd0);
    chk("wr_dq_oe", dqoeCyc - s0, 0);
    chk("wr_oe_windows", oeWin - s1, 4);
    chk("wr_oe_cycles", oeLow - s2, 8);

    // byte read 0x13, then half read 0x12 back-to-back
    s0 = ceWin;
    access(0, 0, 2'd0, 32'h13, 32'h0, -1, lat, rd, flt);
    chk("br_lat", lat, 5);
    chk("br_rdata", rd, 32'h0000_0012);
    chk("br_ce_windows", ceWin - s0, 1);
    access(0, 0, 2'd1, 32'h12, 32'h0, -1, lat, rd, flt);
    chk("hr_lat", lat, 9);
    chk("hr_rdata", rd, 32'h0000_1234);
    @(negedge clk);
    chk("hr_rdata_held", rdA, 32'h0000_1234);

    // misaligned half and illegal size
    s0 = ceWin;
    access(0, 0, 2'd1, 32'h11, 32'h0, -1, lat, rd, flt);
    chk("mis_lat", lat, 1);
    chk("mis_fault", {31'd0, flt}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    access(0, 1, 2'd3, 32'h20, 32'hFFFF_FFFF, -1, lat, rd, flt);
    chk("ill_lat", lat, 1);
    chk("ill_fault", {31'd0, flt}, 32'd1);
    chk("ill_rdata", rd, 32'd0);
    chk("flt_ce_windows", ceWin - s0, 0);
    chk("flt_mem20", {24'd0, memA[19'h20]}, 32'h00);

    // reset asserted during the third byte strobe of a word write
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 2'd2, 32'h40, 32'hAABB_CCDD);
    @(posedge clk);
    @(negedge clk);
    reqA = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("abort_pre_we", {31'd0, weA}, 32'd0);
    chk("abort_pre_addr", 32'(saA), 32'h42);
    rstn = 1'b0;
    #1;
    chk("abort_ce_n", {31'd0, ceA}, 32'd1);
    chk("abort_we_n", {31'd0, weA}, 32'd1);
    chk("abort_dq_oe", {31'd0, dqoeA}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    sawResp = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (respA) sawResp = 1'b1;
    end
    chk("abort_no_resp", {31'd0, sawResp}, 32'd0);
    chk("abort_mem42", {24'd0, memA[19'h42]}, 32'h00);
    access(0, 1, 2'd0, 32'h40, 32'h0000_005A, -1, lat, rd, flt);
    chk("post_bw_lat", lat, 5);
    chk("post_bw_fault", {31'd0, flt}, 32'd0);
    chk("post_bw_mem40", {24'd0, memA[19'h40]}, 32'h5A);
    chk("post_bw_mem41", {24'd0, memA[19'h41]}, 32'hCC);

    // WAIT_CYC=0: half write at top of address space, stray request
    s3 = ceLowB;
    access(1, 1, 2'd1, 32'h7FFFE, 32'h0000_BEEF, 3, lat, rd, flt);
    chk("b_hw_lat", lat, 7);
    chk("b_hw_fault", {31'd0, flt}, 32'd0);
    chk("b_mem7fffe", {24'd0, memB[19'h7FFFE]}, 32'hEF);
    chk("b_mem7ffff", {24'd0, memB[19'h7FFFF]}, 32'hBE);
    chk("b_ce_cycles", ceLowB - s3, 6);
    repeat (6) @(negedge clk);
    chk("b_stray_mem100", {24'd0, memB[19'h100]}, 32'h00);
    chk("b_stray_idle_ce", {31'd0, ceB}, 32'd1);
    access(1, 0, 2'd1, 32'h7FFFE, 32'h0, -1, lat, rd, flt);
    chk("b_hr_lat", lat, 7);
    chk("b_hr_rdata", rd, 32'h0000_BEEF);

    chk("we_oe_overlap", bothLow, 0);
    s4 = 0; s5 = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_sram8_slave.md
Name: bus_sram8_slave

Overview:
- Bus responder (slave end of the data bus) for an external asynchronous SRAM with an 8-bit data path.
- Sits behind one slave port of the data-bus interconnect, e.g. the SRAM window.
- Splits each byte, half or word bus access into sequential byte cycles with programmable strobe width, then returns a single-cycle response.
- Rejects unsupported and misaligned accesses with a fault pulse, without touching the SRAM.

Parameters:
ADDR_W, 19, width of the SRAM byte address; access addresses are taken from s_addr[ADDR_W-1:0].
WAIT_CYC, 1, extra strobe cycles per byte (strobe width = WAIT_CYC+1 clocks); legal range 0..15.

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
s_req  input  1  single-cycle access request; s_addr, s_w_rb, s_acc and s_wdata are valid only in this cycle
s_addr  input  XLEN  byte address
s_w_rb  input  1  1 = write, 0 = read
s_acc  input  clog2(BUS_ACC_CNT)  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal
s_wdata  input  BUS_WIDTH  write data, LSB-justified
s_resp  output  1  single-cycle completion pulse
s_rdata  output  BUS_WIDTH  read data, LSB-justified, zero-extended; valid in the s_resp cycle and held until the next s_resp
s_fault  output  1  pulses together with s_resp for an illegal or misaligned access
sram_ce_n  output  1  chip enable, active low
sram_oe_n  output  1  output enable, active low
sram_we_n  output  1  write enable, active low
sram_addr  output  ADDR_W  SRAM byte address
sram_dq_o  output  8  write data to pad
sram_dq_oe  output  1  pad output enable (1 = drive sram_dq_o)
sram_dq_i  input  8  read data from pad

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state returns to IDLE;
  - sram_ce_n, sram_oe_n and sram_we_n = 1;
  - sram_dq_oe = 0;
  - sram_addr, sram_dq_o, s_rdata = 0;
  - s_resp and s_fault = 0;
  - an aborted access never produces s_resp.
- All outputs are registered.
- States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - on s_req, capture addr/w_rb/acc/wdata;
  - set byte count N = 1, 2 or 4 from s_acc, and byte index k = 0.
- Legality check, performed in IDLE:
  - Illegal means acc = 3, half with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal access: go to RESP with s_fault = 1 and s_rdata = 0. No SRAM pins change.
  - Otherwise go to SETUP.
- SETUP (1 clk):
  - sram_ce_n = 0;
  - sram_addr = captured_addr[ADDR_W-1:0] + k, modulo 2^ADDR_W;
  - for writes, sram_dq_oe = 1 and sram_dq_o = wdata[8k+7:8k].
- STROBE (WAIT_CYC+1 clks):
  - writes: sram_we_n = 0;
  - reads: sram_oe_n = 0;
  - reads: on the last STROBE clock edge, sram_dq_i is captured into byte k of the read buffer.
- HOLD (1 clk):
  - sram_we_n and sram_oe_n = 1;
  - ce_n, addr and dq stay unchanged, giving write data hold time.
  - If k < N-1: k increments and the FSM goes to SETUP.
  - Otherwise: sram_ce_n = 1, sram_dq_oe = 0 at exit, go to RESP.
- RESP (1 clk):
  - s_resp = 1;
  - for reads, s_rdata = read buffer with bytes >= N zeroed;
  - for writes, s_rdata is unchanged;
  - return to IDLE.
  - s_fault is 1 only in a fault RESP.
- Latency:
  - request in cycle T gives s_resp in cycle T + 1 + N*(WAIT_CYC+3);
  - a fault gives s_resp at T+1.
- s_req while not IDLE is a protocol violation: ignored, with no effect on the ongoing access.
- Back-to-back: a new s_req is accepted in the IDLE cycle right after RESP.
- Byte order is little-endian: byte k is the k-th byte from the LSB.
- sram_we_n and sram_oe_n are never low simultaneously.
- sram_dq_oe is never 1 during a read.

Test Plan:
- WAIT_CYC=1, word write 0x12345678 at 0x10 → SRAM[0x10..0x13] = 78,56,34,12; sram_we_n low 2 clks per byte; s_resp at T+17, s_fault=0.
- Word read of 0x10 after that write → s_rdata = 0x12345678 at T+17; sram_dq_oe stays 0; sram_oe_n low for 4 separate 2-clk windows.
- Byte read at 0x13 → s_rdata = 0x00000012 at T+5, exactly one ce_n low window; then a half read at 0x12 → 0x00001234 at T+9.
- Half access at 0x11 and acc=3 at 0x20 → s_resp + s_fault at T+1, s_rdata = 0, sram_ce_n stays 1 throughout.
- rstn asserted during the 3rd byte STROBE of a word write → ce_n/we_n go 1 and dq_oe goes 0 without waiting for clk; no s_resp; a subsequent byte write completes normally at T+5.
- WAIT_CYC=0, ADDR_W=19, half write 0xBEEF at 0x7FFFE → bytes EF, BE at 0x7FFFE and 0x7FFFF; s_resp at T+7; an extra s_req at T+3 is ignored.
